// File: rtl/sum_to_ascii_tx.sv
// Binary-to-ASCII decimal transmitter: iterative double-dabble (one bit per clock)
// followed by a valid/ready character stream, MSD first. Optional macro: ZERO_SUPPRESS_EN.
module sum_to_ascii_tx #(
  parameter int WIDTH = 9,
  parameter int NDIG  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

  state_t           state;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_shifted;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    dig;
  logic [DW-1:0]    start_dig;

  // Per-nibble add-3 correction; nibbles never carry into each other.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_add3
      assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3
                                                           : bcd[4*gi +: 4];
    end
  endgenerate

  assign bcd_shifted = {bcd_adj[BW-2:0], shift[WIDTH-1]};

  // First digit to emit, evaluated on the value the final shift produces.
  always_comb begin
`ifdef ZERO_SUPPRESS_EN
    start_dig = '0;
    for (int i = 1; i < NDIG; i++) begin
      if (bcd_shifted[4*i +: 4] != 4'd0) start_dig = DW'(i);
    end
`else
    start_dig = DW'(NDIG - 1);
`endif
  end

  function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [DW-1:0] idx);
    logic [BW-1:0] t;
    t = b >> (4 * idx);
    return 8'h30 + {4'h0, t[3:0]};
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bcd      <= '0;
      shift    <= '0;
      cnt      <= '0;
      dig      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          if (in_valid) begin
            shift <= in_value;
            bcd   <= '0;
            cnt   <= CW'(WIDTH);
            state <= CONVERT;
          end
        end
        CONVERT: begin
          bcd   <= bcd_shifted;
          shift <= shift << 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= SEND;
            dig      <= start_dig;
            tx_data  <= digit_char(bcd_shifted, start_dig);
            tx_last  <= (start_dig == '0);
            tx_valid <= 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (dig == '0) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
            end else begin
              dig     <= dig - DW'(1);
              tx_data <= digit_char(bcd, dig - DW'(1));
              tx_last <= (dig == DW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
